// File: rtl/regfile_wb_scheduler_pkg.sv
// regfile_pkg: shared constants for the register-file writeback scheduler.
//   NUM_REGS / REG_WIDTH / MUX_CNTRL : register count, data width, id width.
//   WB_ALU / WB_MEM                  : requester index into the 2-bit grant vector.
package regfile_pkg;
    localparam int NUM_REGS  = 32;
    localparam int REG_WIDTH = 32;
    localparam int MUX_CNTRL = 5;

    localparam int WB_ALU = 0;
    localparam int WB_MEM = 1;
endpackage

// File: rtl/regfile_wb_scheduler_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter.
//   Clk, Rst_n : clock, async active-low reset
//   req[1:0]   : request vector, index WB_ALU / WB_MEM
//   grant[1:0] : one-hot (or zero) grant, combinational from req
// A lone requester always wins. On a tie the requester that was not granted
// last wins. The priority pointer moves only when something is granted.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    // prioMem = 1 -> MEM wins a tie, 0 -> ALU wins a tie.
    logic prioMem;

    always_comb begin
        grant         = '0;
        grant[WB_ALU] = req[WB_ALU] & (~req[WB_MEM] | ~prioMem);
        grant[WB_MEM] = req[WB_MEM] & (~req[WB_ALU] |  prioMem);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            prioMem <= 1'b0;
        else if (|grant)
            prioMem <= grant[WB_ALU];   // whoever just won yields the next tie
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: owns the single s_regFile write port and the
// register-busy scoreboard.
//   Clk, Rst_n                      : clock, async active-low reset
//   iss_valid/iss_ready             : issue handshake; ready = no RAW/WAW hazard
//   iss_src_a/iss_src_b             : source register ids
//   iss_has_dest/iss_dest           : destination of the issuing instruction
//   wb0_* (ALU), wb1_* (MEM)        : writeback requesters, valid/ready handshake
//   rf_we/rf_dest/rf_wdata          : registered write port to s_regFile
//   busy                            : bit i set while a write to reg i is pending
//   wb_err                          : sticky, a writeback hit a non-busy register
module regfile_wb_scheduler
    import regfile_pkg::*;
#(
    parameter int NUM_REGS  = regfile_pkg::NUM_REGS,
    parameter int REG_WIDTH = regfile_pkg::REG_WIDTH,
    parameter int MUX_CNTRL = regfile_pkg::MUX_CNTRL
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 iss_valid,
    output logic                 iss_ready,
    input  logic [MUX_CNTRL-1:0] iss_src_a,
    input  logic [MUX_CNTRL-1:0] iss_src_b,
    input  logic                 iss_has_dest,
    input  logic [MUX_CNTRL-1:0] iss_dest,
    input  logic                 wb0_valid,
    output logic                 wb0_ready,
    input  logic [MUX_CNTRL-1:0] wb0_dest,
    input  logic [REG_WIDTH-1:0] wb0_data,
    input  logic                 wb1_valid,
    output logic                 wb1_ready,
    input  logic [MUX_CNTRL-1:0] wb1_dest,
    input  logic [REG_WIDTH-1:0] wb1_data,
    output logic                 rf_we,
    output logic [MUX_CNTRL-1:0] rf_dest,
    output logic [REG_WIDTH-1:0] rf_wdata,
    output logic [NUM_REGS-1:0]  busy,
    output logic                 wb_err
);

    logic [1:0]           grant;
    logic                 accept;
    logic                 accWrite;
    logic [MUX_CNTRL-1:0] accDest;
    logic [REG_WIDTH-1:0] accData;
    logic                 issSet;
    logic [NUM_REGS-1:0]  busyNext;

    rr_arb2 uArb (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .req   ({wb1_valid, wb0_valid}),
        .grant (grant)
    );

    assign wb0_ready = grant[WB_ALU];
    assign wb1_ready = grant[WB_MEM];

    assign accept   = |grant;
    assign accDest  = grant[WB_MEM] ? wb1_dest : wb0_dest;
    assign accData  = grant[WB_MEM] ? wb1_data : wb0_data;
    // Register 0 writes are consumed but never reach the port or the scoreboard.
    assign accWrite = accept && (accDest != '0);

    // busy[0] is held at zero, so reg 0 can never raise a hazard here.
    assign iss_ready = !busy[iss_src_a] && !busy[iss_src_b] &&
                       !(iss_has_dest && busy[iss_dest]);
    assign issSet    = iss_valid && iss_ready && iss_has_dest && (iss_dest != '0);

    always_comb begin
        busyNext = busy;
        if (accWrite)
            busyNext[accDest] = 1'b0;
        if (issSet)
            busyNext[iss_dest] = 1'b1;
        busyNext[0] = 1'b0;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            busy     <= '0;
            rf_we    <= 1'b0;
            rf_dest  <= '0;
            rf_wdata <= '0;
            wb_err   <= 1'b0;
        end else begin
            busy  <= busyNext;
            rf_we <= accWrite;
            if (accept) begin
                rf_dest  <= accDest;
                rf_wdata <= accData;
            end
            if (accWrite && !busy[accDest])
                wb_err <= 1'b1;
        end
    end

    // A busy register blocks issue to it, so set and clear of the same
    // register can only coincide if an unexpected writeback races an issue.
    always @(posedge Clk) begin
        if (Rst_n)
            assert (!(issSet && accWrite && (iss_dest == accDest)))
                else $error("scoreboard set/clear collision on reg %0d", iss_dest);
    end

endmodule
